// File: rtl/arm_issue_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : arm_issue_ctrl
// Description : ID-stage issuer for the EX-stage ALU. Decodes an ARM-subset
//               instruction into exe_cmd plus side-effect controls, evaluates
//               the condition field against forwarded NZCV flags, owns the
//               NZCV status register and registers everything into ID/EX.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               id_valid, instr   - instruction presented in ID
//               alu_status        - {N,Z,C,V} from the ALU for the EX instr
//               stall, flush      - ID/EX hold / bubble insert
//               alu_carry         - status register C bit to the ALU
//               status_reg        - current {N,Z,C,V}
//               ex_*              - registered ID/EX controls and fields
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module arm_issue_ctrl #(
  parameter logic [3:0] SR_RESET = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] instr,
  input  logic [3:0]  alu_status,
  input  logic        stall,
  input  logic        flush,
  output logic        alu_carry,
  output logic [3:0]  status_reg,
  output logic        ex_valid,
  output logic [3:0]  ex_cmd,
  output logic        ex_wb_en,
  output logic        ex_mem_r,
  output logic        ex_mem_w,
  output logic        ex_b,
  output logic        ex_s,
  output logic        ex_imm,
  output logic [3:0]  ex_rn,
  output logic [3:0]  ex_rd,
  output logic [11:0] ex_shift_op,
  output logic [23:0] ex_imm24
);

  // Instruction fields
  logic [3:0] w_cond;
  logic [1:0] w_mode;
  logic [3:0] w_opcode;
  logic       w_s_bit;

  assign w_cond   = instr[31:28];
  assign w_mode   = instr[27:26];
  assign w_opcode = instr[24:21];
  assign w_s_bit  = instr[20];

  // Raw decode, before condition/validity qualification
  logic [3:0] w_cmd;
  logic       w_wb_en, w_mem_r, w_mem_w, w_b, w_s, w_legal;

  always_comb begin
    w_cmd   = 4'b0000;
    w_wb_en = 1'b0;
    w_mem_r = 1'b0;
    w_mem_w = 1'b0;
    w_b     = 1'b0;
    w_s     = 1'b0;
    w_legal = 1'b0;
    case (w_mode)
      2'b00: begin
        w_legal = 1'b1;
        w_wb_en = 1'b1;
        w_s     = w_s_bit;
        case (w_opcode)
          4'b1101: w_cmd = 4'b0001;  // MOV
          4'b1111: w_cmd = 4'b1001;  // MVN
          4'b0100: w_cmd = 4'b0010;  // ADD
          4'b0101: w_cmd = 4'b0011;  // ADC
          4'b0010: w_cmd = 4'b0100;  // SUB
          4'b0110: w_cmd = 4'b0101;  // SBC
          4'b0000: w_cmd = 4'b0110;  // AND
          4'b1100: w_cmd = 4'b0111;  // ORR
          4'b0001: w_cmd = 4'b1000;  // EOR
          4'b1010: begin             // CMP: flags only
            w_cmd   = 4'b0100;
            w_wb_en = 1'b0;
            w_s     = 1'b1;
          end
          4'b1000: begin             // TST: flags only
            w_cmd   = 4'b0110;
            w_wb_en = 1'b0;
            w_s     = 1'b1;
          end
          default: begin
            w_legal = 1'b0;
            w_wb_en = 1'b0;
            w_s     = 1'b0;
          end
        endcase
      end
      2'b01: begin
        w_legal = 1'b1;
        w_cmd   = 4'b0010;           // address = base + offset
        w_mem_r = w_s_bit;           // L bit selects load vs store
        w_wb_en = w_s_bit;
        w_mem_w = ~w_s_bit;
      end
      2'b10: begin
        w_legal = 1'b1;
        w_b     = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Flags seen by the condition check: a flag-setting instruction still in EX
  // has not yet written the status register, so its ALU result is forwarded.
  logic [3:0] w_flags;
  logic       w_n, w_z, w_c, w_v;
  logic       w_cond_pass;
  logic       w_effective;

  assign w_flags = (ex_valid & ex_s) ? alu_status : status_reg;
  assign {w_n, w_z, w_c, w_v} = w_flags;

  always_comb begin
    w_cond_pass = 1'b0;
    case (w_cond)
      4'b0000: w_cond_pass = w_z;
      4'b0001: w_cond_pass = ~w_z;
      4'b0010: w_cond_pass = w_c;
      4'b0011: w_cond_pass = ~w_c;
      4'b0100: w_cond_pass = w_n;
      4'b0101: w_cond_pass = ~w_n;
      4'b0110: w_cond_pass = w_v;
      4'b0111: w_cond_pass = ~w_v;
      4'b1000: w_cond_pass = w_c & ~w_z;
      4'b1001: w_cond_pass = ~w_c | w_z;
      4'b1010: w_cond_pass = (w_n == w_v);
      4'b1011: w_cond_pass = (w_n != w_v);
      4'b1100: w_cond_pass = ~w_z & (w_n == w_v);
      4'b1101: w_cond_pass = w_z | (w_n != w_v);
      4'b1110: w_cond_pass = 1'b1;
      default: w_cond_pass = 1'b0;
    endcase
  end

  assign w_effective = id_valid & w_cond_pass & w_legal;

  // Status register and ID/EX pipeline register
  logic [3:0]  r_sr;
  logic        r_valid, r_wb_en, r_mem_r, r_mem_w, r_b, r_s, r_imm;
  logic [3:0]  r_cmd, r_rn, r_rd;
  logic [11:0] r_shift_op;
  logic [23:0] r_imm24;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr       <= SR_RESET;
      r_valid    <= 1'b0;
      r_cmd      <= 4'b0000;
      r_wb_en    <= 1'b0;
      r_mem_r    <= 1'b0;
      r_mem_w    <= 1'b0;
      r_b        <= 1'b0;
      r_s        <= 1'b0;
      r_imm      <= 1'b0;
      r_rn       <= 4'b0000;
      r_rd       <= 4'b0000;
      r_shift_op <= 12'h000;
      r_imm24    <= 24'h000000;
    end else begin
      // The EX instruction is older than any branch causing a flush, so its
      // flag write is kept even when flush is asserted.
      if (r_valid & r_s & ~stall)
        r_sr <= alu_status;

      if (flush) begin
        r_valid    <= 1'b0;
        r_cmd      <= 4'b0000;
        r_wb_en    <= 1'b0;
        r_mem_r    <= 1'b0;
        r_mem_w    <= 1'b0;
        r_b        <= 1'b0;
        r_s        <= 1'b0;
        r_imm      <= 1'b0;
        r_rn       <= 4'b0000;
        r_rd       <= 4'b0000;
        r_shift_op <= 12'h000;
        r_imm24    <= 24'h000000;
      end else if (!stall) begin
        r_valid    <= w_effective;
        r_cmd      <= w_effective ? w_cmd   : 4'b0000;
        r_wb_en    <= w_effective & w_wb_en;
        r_mem_r    <= w_effective & w_mem_r;
        r_mem_w    <= w_effective & w_mem_w;
        r_b        <= w_effective & w_b;
        r_s        <= w_effective & w_s;
        // Fields load unconditionally; consumers qualify with ex_valid.
        r_imm      <= instr[25];
        r_rn       <= instr[19:16];
        r_rd       <= instr[15:12];
        r_shift_op <= instr[11:0];
        r_imm24    <= instr[23:0];
      end
    end
  end

  assign status_reg  = r_sr;
  assign alu_carry   = r_sr[1];
  assign ex_valid    = r_valid;
  assign ex_cmd      = r_cmd;
  assign ex_wb_en    = r_wb_en;
  assign ex_mem_r    = r_mem_r;
  assign ex_mem_w    = r_mem_w;
  assign ex_b        = r_b;
  assign ex_s        = r_s;
  assign ex_imm      = r_imm;
  assign ex_rn       = r_rn;
  assign ex_rd       = r_rd;
  assign ex_shift_op = r_shift_op;
  assign ex_imm24    = r_imm24;

endmodule
`default_nettype wire

// File: tb/tb_arm_issue_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_arm_issue_ctrl
// Description : Scoreboard bench for arm_issue_ctrl. Stimulus computes the
//               expected post-edge state from a behavioural model and queues
//               it; a monitor pops one entry per clock edge and compares.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_arm_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst, id_valid, stall, flush;
  logic [31:0] instr;
  logic [3:0]  alu_status;
  logic        alu_carry, ex_valid, ex_wb_en, ex_mem_r, ex_mem_w, ex_b, ex_s, ex_imm;
  logic [3:0]  status_reg, ex_cmd, ex_rn, ex_rd;
  logic [11:0] ex_shift_op;
  logic [23:0] ex_imm24;

  arm_issue_ctrl #(.SR_RESET(4'b0000)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .instr(instr),
    .alu_status(alu_status), .stall(stall), .flush(flush),
    .alu_carry(alu_carry), .status_reg(status_reg), .ex_valid(ex_valid),
    .ex_cmd(ex_cmd), .ex_wb_en(ex_wb_en), .ex_mem_r(ex_mem_r),
    .ex_mem_w(ex_mem_w), .ex_b(ex_b), .ex_s(ex_s), .ex_imm(ex_imm),
    .ex_rn(ex_rn), .ex_rd(ex_rd), .ex_shift_op(ex_shift_op),
    .ex_imm24(ex_imm24)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [3:0]  cmd;
    logic        wb, mr, mw, b, s, imm;
    logic [3:0]  rn, rd;
    logic [11:0] shop;
    logic [23:0] imm24;
  } ex_t;

  typedef struct packed {
    ex_t        ex;
    logic [3:0] sr;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Model state (what the DUT should hold after the last queued edge)
  ex_t        m_ex = '0;
  logic [3:0] m_sr = 4'b0000;

  // Condition: pairs of codes test one predicate, odd code inverts it.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] fl);
    logic n, z, cy, v, r;
    {n, z, cy, v} = fl;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? !r : r;
  endfunction

  function automatic ex_t decode(input logic [31:0] ins, input logic v, input logic [3:0] fl);
    ex_t        d;
    logic       legal;
    logic [3:0] op;
    d       = '0;
    legal   = 1'b1;
    op      = ins[24:21];
    d.imm   = ins[25];
    d.rn    = ins[19:16];
    d.rd    = ins[15:12];
    d.shop  = ins[11:0];
    d.imm24 = ins[23:0];
    if (ins[27:26] == 2'b00) begin
      d.wb = 1'b1;
      d.s  = ins[20];
      if      (op == 4'hD) d.cmd = 4'h1;
      else if (op == 4'hF) d.cmd = 4'h9;
      else if (op == 4'h4) d.cmd = 4'h2;
      else if (op == 4'h5) d.cmd = 4'h3;
      else if (op == 4'h2) d.cmd = 4'h4;
      else if (op == 4'h6) d.cmd = 4'h5;
      else if (op == 4'h0) d.cmd = 4'h6;
      else if (op == 4'hC) d.cmd = 4'h7;
      else if (op == 4'h1) d.cmd = 4'h8;
      else if (op == 4'hA) begin d.cmd = 4'h4; d.wb = 1'b0; d.s = 1'b1; end
      else if (op == 4'h8) begin d.cmd = 4'h6; d.wb = 1'b0; d.s = 1'b1; end
      else legal = 1'b0;
    end else if (ins[27:26] == 2'b01) begin
      d.cmd = 4'h2;
      if (ins[20]) begin d.mr = 1'b1; d.wb = 1'b1; end
      else d.mw = 1'b1;
    end else if (ins[27:26] == 2'b10) begin
      d.b = 1'b1;
    end else legal = 1'b0;
    d.valid = v && legal && cond_ok(ins[31:28], fl);
    if (!d.valid) begin
      d.cmd = 4'h0; d.wb = 1'b0; d.mr = 1'b0; d.mw = 1'b0; d.b = 1'b0; d.s = 1'b0;
    end
    return d;
  endfunction

  // Drive one cycle of inputs, advance the model, queue the expectation.
  task automatic step(input logic r, input logic [31:0] ins, input logic v,
                      input logic [3:0] st, input logic stl, input logic fl);
    logic [3:0] flags;
    exp_t       e;
    rst = r; instr = ins; id_valid = v; alu_status = st; stall = stl; flush = fl;
    if (r) begin
      m_ex = '0;
      m_sr = 4'b0000;
    end else begin
      flags = (m_ex.valid && m_ex.s) ? st : m_sr;
      if (m_ex.valid && m_ex.s && !stl) m_sr = st;
      if (fl)        m_ex = '0;
      else if (!stl) m_ex = decode(ins, v, flags);
    end
    e.ex = m_ex;
    e.sr = m_sr;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expectation per edge, sampled 1 time unit after the edge
  exp_t mon_e;
  ex_t  mon_act;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = {ex_valid, ex_cmd, ex_wb_en, ex_mem_r, ex_mem_w, ex_b, ex_s,
                 ex_imm, ex_rn, ex_rd, ex_shift_op, ex_imm24};
      checks++;
      if (mon_act !== mon_e.ex) begin
        errors++;
        $display("FAIL ex_regs t=%0t got=%h want=%h", $time, mon_act, mon_e.ex);
      end
      checks++;
      if (status_reg !== mon_e.sr) begin
        errors++;
        $display("FAIL status_reg t=%0t got=%b want=%b", $time, status_reg, mon_e.sr);
      end
      checks++;
      if (alu_carry !== mon_e.sr[1]) begin
        errors++;
        $display("FAIL alu_carry t=%0t got=%b want=%b", $time, alu_carry, mon_e.sr[1]);
      end
    end
  end

  localparam logic [31:0] C_ADDS  = 32'hE0912003;
  localparam logic [31:0] C_CMP   = 32'hE1510002;
  localparam logic [31:0] C_MOVEQ = 32'h03A00005;
  localparam logic [31:0] C_LDR   = 32'hE5912004;
  localparam logic [31:0] C_STR   = 32'hE5812004;
  localparam logic [31:0] C_B     = 32'hEA000010;
  localparam logic [31:0] C_RSB   = 32'hE0612003;
  localparam logic [31:0] C_NV    = 32'hF0912003;

  initial begin
    rst = 1'b1; instr = '0; id_valid = 1'b0; alu_status = '0; stall = 1'b0; flush = 1'b0;
    #2;
    // Reset with garbage in ID
    step(1, 32'hDEADBEEF, 1, 4'hF, 1, 1);
    // Decode and status write
    step(0, C_ADDS, 1, 4'h0, 0, 0);
    step(0, 32'h0, 0, 4'b0110, 0, 0);
    step(0, 32'h0, 0, 4'h0, 0, 0);
    // Forwarding: CMP in EX, MOVEQ in ID, Z set by ALU
    step(0, C_CMP, 1, 4'h0, 0, 0);
    step(0, C_MOVEQ, 1, 4'b0100, 0, 0);
    step(0, C_CMP, 1, 4'h0, 0, 0);
    step(0, C_MOVEQ, 1, 4'b0000, 0, 0);
    // Memory and branch
    step(0, C_LDR, 1, 4'h0, 0, 0);
    step(0, C_STR, 1, 4'h0, 0, 0);
    step(0, C_B, 1, 4'h0, 0, 0);
    // Stall with a flag-setter in EX: everything holds
    step(0, C_ADDS, 1, 4'h0, 0, 0);
    step(0, C_LDR, 1, 4'b1001, 1, 0);
    step(0, C_STR, 1, 4'b1111, 1, 0);
    step(0, C_B, 1, 4'b0011, 1, 0);
    // Stall plus flush: bubble wins, status held because of stall
    step(0, C_MOVEQ, 1, 4'b1010, 1, 1);
    // Flush with a flag-setter in EX: status still updated
    step(0, C_CMP, 1, 4'h0, 0, 0);
    step(0, C_B, 1, 4'b1100, 0, 1);
    // Illegal opcode and never condition
    step(0, C_RSB, 1, 4'h0, 0, 0);
    step(0, C_NV, 1, 4'h0, 0, 0);
    // Reset while stalled and flushed
    step(0, C_ADDS, 1, 4'h0, 0, 0);
    step(1, C_CMP, 1, 4'hF, 1, 1);
    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 3) == 0) ins[31:28] = 4'hE;
      if ($urandom_range(0, 2) == 0) ins[27:26] = 2'b00;
      step($urandom_range(0, 63) == 0, ins, $urandom_range(0, 7) != 0,
           4'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain left=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arm_issue_ctrl.md
Name: arm_issue_ctrl

Overview:
- ID-stage issuer for the EX-stage ALU; the control end of the ALU interface.
- Decodes a 32-bit ARM-subset instruction into exe_cmd and side-effect controls, and evaluates the condition field against forwarded flags.
- Owns the NZCV status register, written from the ALU's Status_Bits, and supplies the carry input back to the ALU.
- Registers all controls into the ID/EX pipeline register, with stall and flush.

Parameters:
SR_RESET, 4'b0000, reset value of status register {N,Z,C,V}

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
id_valid  in  1  instr holds a valid fetched instruction
instr  in  32  instruction in ID
alu_status  in  4  {N,Z,C,V} from ALU for instruction currently in EX
stall  in  1  hold ID/EX register and status register
flush  in  1  load bubble into ID/EX (taken branch)
alu_carry  out  1  status register C bit (sr[1]) driven to the ALU
status_reg  out  4  current status register
ex_valid  out  1  registered: EX slot holds an effective instruction
ex_cmd  out  4  registered exe_cmd
ex_wb_en, ex_mem_r, ex_mem_w, ex_b, ex_s  out  1 each  registered controls
ex_imm  out  1  registered I bit (instr[25])
ex_rn, ex_rd  out  4 each  registered instr[19:16], instr[15:12]
ex_shift_op  out  12  registered instr[11:0]
ex_imm24  out  24  registered instr[23:0]

Behaviour:
- Fields: cond=[31:28], mode=[27:26], I=[25], opcode=[24:21], S=[20] (L for memory instructions).
- mode 00 opcode -> exe_cmd, wb_en:
  - MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000: wb_en=1.
  - CMP 1010->0100, TST 1000->0110: wb_en=0, s forced 1.
  - Any other opcode is illegal.
  - For legal ops other than CMP/TST, s = S.
- mode 01: exe_cmd=0010, s=0.
  - L=1: mem_r=1, wb_en=1.
  - L=0: mem_w=1.
- mode 10: b=1, exe_cmd=0000, s=0. mode 11 is illegal.
- Flags for the condition check (forwarding): eff = (ex_valid & ex_s) ? alu_status : status_reg.
- Condition on eff:
  - EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V.
  - HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V).
  - AL 1; 1111 -> 0.
- effective = id_valid & cond_pass & legal.
- When not effective, all of ex_cmd, wb_en, mem_r, mem_w, b, s load 0 and ex_valid loads 0. The field outputs (rn, rd, shift_op, imm24, imm) still load instr.
- ID/EX update priority per edge: rst > flush > stall > load.
  - rst: every ex_* output = 0; status_reg = SR_RESET.
  - flush: ex_valid and all controls = 0; fields unspecified (load 0). Flush overrides stall.
  - stall (no flush): all ex_* hold.
  - Otherwise load the decoded values.
- Status register:
  - Written sr <= alu_status on the edge when ex_valid & ex_s & ~stall & ~rst.
  - Written even when flush is asserted: the EX instruction is older than the branch.
  - Otherwise holds.
- alu_carry = status_reg[1]. This is combinational from the register, so the instruction in EX sees flags of all older instructions.
- Latency: decode to ex_* is 1 cycle. The status write lands at the end of the flag-setting instruction's EX cycle.
- Reset mid-stall or mid-flush: rst wins, giving a clean bubble and SR_RESET.

Test Plan:
- Reset: rst=1 one cycle with garbage instr -> all ex_* = 0, status_reg = 0000, alu_carry = 0.
- Decode: instr 0xE0912003 (ADDS r2,r1,r3), id_valid=1 -> next cycle ex_valid=1, ex_cmd=0010, ex_wb_en=1, ex_s=1, ex_rn=1, ex_rd=2. alu_status=0110 that cycle -> status_reg=0110, alu_carry=1 the following cycle.
- Forwarding: CMP (0xE1510002) in EX with alu_status=0100, ID holds MOVEQ (0x03A00005) -> MOVEQ issues (ex_valid=1, ex_cmd=0001). Repeat with alu_status=0000 -> ex_valid=0, ex_wb_en=0, and status_reg=0000 after the edge.
- Memory and branch:
  - LDR 0xE5912004 -> ex_cmd=0010, ex_mem_r=1, ex_wb_en=1.
  - STR 0xE5812004 -> ex_mem_w=1, ex_wb_en=0.
  - B 0xEA000010 -> ex_b=1, ex_imm24=0x000010.
- Stall and flush:
  - stall=1 for 3 cycles while instr changes -> ex_* constant, status_reg constant.
  - stall=1 with flush=1 -> ex_valid=0 next cycle.
  - flush with a flag-setting instruction in EX -> status_reg still updated.
- Illegal and never: opcode 0011 (RSB) or cond 1111 -> ex_valid=0, all controls 0, status_reg unaffected.
